csm_shared_mem: RTL and testbench
=================================

// Module: csm_shared_mem
// PURPOSE
//  Shared-memory responder for the CSM design: serves two processors (A, B) over a
//  multiplexed address/data bus with read, write, hold (exclusive lock) and release.
//  Sits between the processor-side drivers and a DEPTH-byte register-file memory.
//  Arbitrates the lock and same-address write conflicts, and reports errors per port.
// PARAMETERS
//  DATABITS  8    address and data width (AD bus is shared)
//  ERRBITS   2    error code width
//  DEPTH     256  memory words; must equal 2**DATABITS
// PORTS
//  clk            in   1         system clock, all state on posedge
//  reset          in   1         asynchronous, active-high reset
//  A_in_AD        in   DATABITS  A address (command cycle) / write data (data cycle)
//  A_rw           in   1         1=write, 0=read; sampled with A_enable
//  A_enable       in   1         A command strobe
//  A_hold         in   1         A lock request; sampled with A_enable
//  A_release      in   1         A unlock request; sampled with A_enable
//  A_ack          out  1         1=port A idle/ready; 0=response cycle
//  A_err          out  ERRBITS   A status, valid while A_ack=0
//  A_out_data     out  DATABITS  A read data, valid while A_ack=0 after a read
//  B_*            -    -         identical set for processor B
// BEHAVIOUR
//  Reset (async): X_ack=1, X_err=0, X_out_data=0, FSMs IDLE, lock FREE, prio=A,
//   memory cleared to 0; in-flight writes dropped.
//  Per-port FSM (A and B independent): IDLE, RESP, WR_DATA.
//   IDLE: command accepted on posedge with X_enable=1 and X_ack=1; decode order
//    hold&release -> release -> hold -> rw.
//   Read: at accept edge E0 X_out_data<=mem[AD] (value before any write committing
//    at E0); ->RESP. X_ack=0 for one cycle, back to 1 at E1.
//   Write: E0 latch address, X_ack<=0, ->WR_DATA; E1 sample AD as data, mem[addr]
//    <=data, X_ack<=1, ->IDLE. Total ack-low: exactly one cycle.
//   Hold/Release: resolved at E0, ->RESP, ack low one cycle.
//   RESP: ->IDLE, X_ack<=1, X_err<=0. X_out_data holds last read value.
//   X_enable while X_ack=0 is ignored.
//  Lock: states FREE, OWN_A, OWN_B.
//   hold: FREE or own -> own (idempotent), err 00; other owns -> err 01.
//   release: own -> FREE, err 00; not owner -> err 10, lock unchanged.
//   read/write while other port owns lock -> err 01, no memory or out_data change.
//    A denied write still takes its data cycle (WR_DATA) but commits nothing.
//   Owner may read/write freely; lock persists until release or reset.
//  Error codes: 00 OK, 01 LOCKED, 10 NOT_OWNER, 11 COLLISION.
//   COLLISION: hold and release both set (no lock change), or losing port of a
//   same-address write conflict.
//  Simultaneous events, same E0:
//   both hold on FREE lock: prio port gets lock, other err 01; prio toggles.
//   both write, equal address: prio port commits, other err 11 (no commit); prio
//    toggles. Different addresses: both commit.
//   read + write, same address: read returns old value.
//   Staggered writes, same address: later commit wins.
//  Reset mid-write (between E0 and E1): no commit, all outputs to reset values.
// TESTING
//  1 Reset, A write 0x10<-0x5A, A read 0x10 -> A_ack low 1 cycle, A_out_data=0x5A, A_err=00.
//  2 A hold; B write 0x20<-0x33 -> B_err=01, mem[0x20] stays 0x00; A release, B write -> committed.
//  3 B release with lock FREE -> B_err=10; A hold+release same cycle -> A_err=11, lock FREE.
//  4 A,B write 0x40 same edge (A<-0x11, B<-0x22) -> mem=0x11, B_err=11;
//     repeat -> mem=0x22, A_err=11.
//  5 A write 0x80<-0xC3 data cycle, B read 0x80 same edge -> B_out_data=0x00; re-read -> 0xC3.
//  6 Assert reset between write address and data cycle -> mem unchanged (0), acks=1, lock FREE.

Source files
------------

// File: rtl/csm_shared_mem.sv
// Shared-memory responder for two processors (A = index 0, B = index 1) over a muxed AD bus.
// Handles read/write/hold/release, the exclusive lock, and same-address write arbitration.
module csm_shared_mem #(
  parameter int DATABITS = 8,
  parameter int ERRBITS  = 2,
  parameter int DEPTH    = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATABITS-1:0] A_in_AD,
  input  logic                A_rw,
  input  logic                A_enable,
  input  logic                A_hold,
  input  logic                A_release,
  output logic                A_ack,
  output logic [ERRBITS-1:0]  A_err,
  output logic [DATABITS-1:0] A_out_data,
  input  logic [DATABITS-1:0] B_in_AD,
  input  logic                B_rw,
  input  logic                B_enable,
  input  logic                B_hold,
  input  logic                B_release,
  output logic                B_ack,
  output logic [ERRBITS-1:0]  B_err,
  output logic [DATABITS-1:0] B_out_data,
  output logic [5:0]          dbg_state_o  // {lock, B port state, A port state}
);

  // Handshake: a command is taken on a posedge where X_enable=1 and X_ack=1;
  // X_ack then stays low for exactly one cycle while X_err/X_out_data are valid.
  typedef enum logic [1:0] {P_IDLE, P_RESP, P_WR_DATA} port_state_t;
  typedef enum logic [1:0] {L_FREE, L_OWN_A, L_OWN_B} lock_state_t;

  localparam logic [ERRBITS-1:0] ERR_OK        = ERRBITS'(0);
  localparam logic [ERRBITS-1:0] ERR_LOCKED    = ERRBITS'(1);
  localparam logic [ERRBITS-1:0] ERR_NOT_OWNER = ERRBITS'(2);
  localparam logic [ERRBITS-1:0] ERR_COLLISION = ERRBITS'(3);

  logic [DATABITS-1:0] ad [2];
  logic [1:0] en, rw, hd, rl;

  assign ad[0] = A_in_AD;
  assign ad[1] = B_in_AD;
  assign en    = {B_enable, A_enable};
  assign rw    = {B_rw, A_rw};
  assign hd    = {B_hold, A_hold};
  assign rl    = {B_release, A_release};

  port_state_t         st_q   [2], st_d   [2];
  logic [1:0]          ack_q, ack_d, go_q, go_d;
  logic [ERRBITS-1:0]  err_q  [2], err_d  [2];
  logic [DATABITS-1:0] out_q  [2], out_d  [2];
  logic [DATABITS-1:0] addr_q [2], addr_d [2];
  lock_state_t         lock_q, lock_d;
  logic                prio_q, prio_d;  // 0 = A wins the next contested event
  logic [DATABITS-1:0] mem_q  [DEPTH];

  logic [1:0] accept, own, other, hold_cmd, wr_cmd, grant, rel_ok;
  logic       both_hold_free, both_wr_same;

  assign own   = {lock_q == L_OWN_B, lock_q == L_OWN_A};
  assign other = {lock_q == L_OWN_A, lock_q == L_OWN_B};

  always_comb begin
    accept   = en & ack_q;
    hold_cmd = accept & hd & ~rl;
    wr_cmd   = accept & ~hd & ~rl & rw;
    both_hold_free = (&hold_cmd) && (lock_q == L_FREE);
    // Only a contest between two permitted writers; a locked-out writer is already denied.
    both_wr_same   = (&wr_cmd) && !(|other) && (ad[0] == ad[1]);
    lock_d = lock_q;
    prio_d = prio_q;
    grant  = '0;
    rel_ok = '0;
    for (int p = 0; p < 2; p++) begin
      st_d[p]   = st_q[p];
      ack_d[p]  = ack_q[p];
      err_d[p]  = err_q[p];
      out_d[p]  = out_q[p];
      addr_d[p] = addr_q[p];
      go_d[p]   = go_q[p];
      case (st_q[p])
        P_IDLE: begin
          if (accept[p]) begin
            ack_d[p] = 1'b0;
            st_d[p]  = P_RESP;
            err_d[p] = ERR_OK;
            if (hd[p] && rl[p]) begin
              err_d[p] = ERR_COLLISION;
            end else if (rl[p]) begin
              if (own[p]) rel_ok[p] = 1'b1;
              else        err_d[p]  = ERR_NOT_OWNER;
            end else if (hd[p]) begin
              if (other[p] || (both_hold_free && prio_q != 1'(p))) err_d[p] = ERR_LOCKED;
              else                                                 grant[p] = 1'b1;
            end else if (rw[p]) begin
              st_d[p]   = P_WR_DATA;
              addr_d[p] = ad[p];
              go_d[p]   = 1'b0;
              if (other[p])                                    err_d[p] = ERR_LOCKED;
              else if (both_wr_same && prio_q != 1'(p))        err_d[p] = ERR_COLLISION;
              else                                             go_d[p]  = 1'b1;
            end else begin
              if (other[p]) err_d[p] = ERR_LOCKED;
              else          out_d[p] = mem_q[ad[p]];
            end
          end
        end
        P_RESP, P_WR_DATA: begin
          st_d[p]  = P_IDLE;
          ack_d[p] = 1'b1;
          err_d[p] = ERR_OK;
        end
        default: begin
          st_d[p]  = P_IDLE;
          ack_d[p] = 1'b1;
        end
      endcase
    end
    if (both_hold_free || both_wr_same) prio_d = ~prio_q;
    if (grant[0])            lock_d = L_OWN_A;
    else if (grant[1])       lock_d = L_OWN_B;
    else if (|rel_ok)        lock_d = L_FREE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        st_q[p]   <= P_IDLE;
        err_q[p]  <= ERR_OK;
        out_q[p]  <= '0;
        addr_q[p] <= '0;
      end
      ack_q  <= 2'b11;
      go_q   <= 2'b00;
      lock_q <= L_FREE;
      prio_q <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        st_q[p]   <= st_d[p];
        err_q[p]  <= err_d[p];
        out_q[p]  <= out_d[p];
        addr_q[p] <= addr_d[p];
      end
      ack_q  <= ack_d;
      go_q   <= go_d;
      lock_q <= lock_d;
      prio_q <= prio_d;
    end
  end

  // Commit happens on the data cycle; same-edge reads see the pre-commit value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (st_q[p] == P_WR_DATA && go_q[p]) mem_q[addr_q[p]] <= ad[p];
      end
    end
  end

  assign A_ack       = ack_q[0];
  assign B_ack       = ack_q[1];
  assign A_err       = err_q[0];
  assign B_err       = err_q[1];
  assign A_out_data  = out_q[0];
  assign B_out_data  = out_q[1];
  assign dbg_state_o = {lock_q, st_q[1], st_q[0]};

endmodule

// File: tb/tb_csm_shared_mem.sv
// Directed bench for csm_shared_mem: inputs driven on negedge, outputs checked on the next negedge.
module tb_csm_shared_mem;

  logic       clk, reset;
  logic [7:0] A_in_AD, B_in_AD;
  logic       A_rw, A_enable, A_hold, A_release;
  logic       B_rw, B_enable, B_hold, B_release;
  logic       A_ack, B_ack;
  logic [1:0] A_err, B_err;
  logic [7:0] A_out_data, B_out_data;
  logic [5:0] dbg_state_o;

  int vectors;
  int miscompares;

  csm_shared_mem dut (
    .clk(clk), .reset(reset),
    .A_in_AD(A_in_AD), .A_rw(A_rw), .A_enable(A_enable), .A_hold(A_hold),
    .A_release(A_release), .A_ack(A_ack), .A_err(A_err), .A_out_data(A_out_data),
    .B_in_AD(B_in_AD), .B_rw(B_rw), .B_enable(B_enable), .B_hold(B_hold),
    .B_release(B_release), .B_ack(B_ack), .B_err(B_err), .B_out_data(B_out_data),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int p, input logic en, input logic w, input logic h,
                       input logic r, input logic [7:0] ad);
    if (p == 0) begin
      A_enable = en; A_rw = w; A_hold = h; A_release = r; A_in_AD = ad;
    end else begin
      B_enable = en; B_rw = w; B_hold = h; B_release = r; B_in_AD = ad;
    end
  endtask

  function automatic logic [7:0] ack_of(input int p);
    return (p == 0) ? {7'd0, A_ack} : {7'd0, B_ack};
  endfunction
  function automatic logic [7:0] err_of(input int p);
    return (p == 0) ? {6'd0, A_err} : {6'd0, B_err};
  endfunction
  function automatic logic [7:0] out_of(input int p);
    return (p == 0) ? A_out_data : B_out_data;
  endfunction
  function automatic logic [7:0] lock_of();
    logic [5:0] d;
    d = dbg_state_o;
    return {6'd0, d[5:4]};
  endfunction

  task automatic wr_cmd(input string tag, input int p, input logic [7:0] addr,
                        input logic [7:0] data, input logic [7:0] exp_err);
    drive(p, 1, 1, 0, 0, addr);
    @(negedge clk);
    check({tag, "_ack_lo"}, ack_of(p), 8'd0);
    check({tag, "_err"}, err_of(p), exp_err);
    drive(p, 0, 0, 0, 0, data);
    @(negedge clk);
    check({tag, "_ack_hi"}, ack_of(p), 8'd1);
  endtask

  task automatic rd_cmd(input string tag, input int p, input logic [7:0] addr,
                        input logic [7:0] exp_data, input logic [7:0] exp_err);
    drive(p, 1, 0, 0, 0, addr);
    @(negedge clk);
    check({tag, "_ack_lo"}, ack_of(p), 8'd0);
    check({tag, "_err"}, err_of(p), exp_err);
    check({tag, "_data"}, out_of(p), exp_data);
    drive(p, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    check({tag, "_ack_hi"}, ack_of(p), 8'd1);
  endtask

  task automatic ctl_cmd(input string tag, input int p, input logic h, input logic r,
                         input logic [7:0] exp_err);
    drive(p, 1, 0, h, r, 8'h00);
    @(negedge clk);
    check({tag, "_ack_lo"}, ack_of(p), 8'd0);
    check({tag, "_err"}, err_of(p), exp_err);
    drive(p, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    check({tag, "_ack_hi"}, ack_of(p), 8'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_a_ack", ack_of(0), 8'd1);
    check("rst_b_ack", ack_of(1), 8'd1);
    check("rst_a_err", err_of(0), 8'd0);
    check("rst_b_out", out_of(1), 8'd0);
    check("rst_lock",  lock_of(), 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic write then read
    wr_cmd("t1_wr", 0, 8'h10, 8'h5A, 8'd0);
    rd_cmd("t1_rd", 0, 8'h10, 8'h5A, 8'd0);

    // 2: lock blocks the other port until released
    ctl_cmd("t2_hold", 0, 1, 0, 8'd0);
    check("t2_lock_a", lock_of(), 8'd1);
    wr_cmd("t2_b_wr_denied", 1, 8'h20, 8'h33, 8'd1);
    rd_cmd("t2_a_rd_20", 0, 8'h20, 8'h00, 8'd0);
    rd_cmd("t2_b_rd_denied", 1, 8'h10, 8'h00, 8'd1);
    ctl_cmd("t2_rel", 0, 0, 1, 8'd0);
    check("t2_lock_free", lock_of(), 8'd0);
    wr_cmd("t2_b_wr", 1, 8'h20, 8'h33, 8'd0);
    rd_cmd("t2_b_rd", 1, 8'h20, 8'h33, 8'd0);

    // 3: release without ownership, hold+release together
    ctl_cmd("t3_b_rel", 1, 0, 1, 8'd2);
    ctl_cmd("t3_a_hr", 0, 1, 1, 8'd3);
    check("t3_lock_free", lock_of(), 8'd0);

    // 4: same-address write collisions alternate winners
    drive(0, 1, 1, 0, 0, 8'h40);
    drive(1, 1, 1, 0, 0, 8'h40);
    @(negedge clk);
    check("t4a_a_err", err_of(0), 8'd0);
    check("t4a_b_err", err_of(1), 8'd3);
    drive(0, 0, 0, 0, 0, 8'h11);
    drive(1, 0, 0, 0, 0, 8'h22);
    @(negedge clk);
    check("t4a_b_ack", ack_of(1), 8'd1);
    rd_cmd("t4a_rd", 0, 8'h40, 8'h11, 8'd0);
    drive(0, 1, 1, 0, 0, 8'h40);
    drive(1, 1, 1, 0, 0, 8'h40);
    @(negedge clk);
    check("t4b_a_err", err_of(0), 8'd3);
    check("t4b_b_err", err_of(1), 8'd0);
    drive(0, 0, 0, 0, 0, 8'h11);
    drive(1, 0, 0, 0, 0, 8'h22);
    @(negedge clk);
    rd_cmd("t4b_rd", 1, 8'h40, 8'h22, 8'd0);
    // both hold on a free lock: priority is back with A
    drive(0, 1, 0, 1, 0, 8'h00);
    drive(1, 1, 0, 1, 0, 8'h00);
    @(negedge clk);
    check("t4c_a_err", err_of(0), 8'd0);
    check("t4c_b_err", err_of(1), 8'd1);
    check("t4c_lock", lock_of(), 8'd1);
    drive(0, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    ctl_cmd("t4c_rel", 0, 0, 1, 8'd0);

    // 5: read on the same edge as a commit sees the old value
    drive(0, 1, 1, 0, 0, 8'h80);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8'hC3);
    drive(1, 1, 0, 0, 0, 8'h80);
    @(negedge clk);
    check("t5_b_ack_lo", ack_of(1), 8'd0);
    check("t5_b_old", out_of(1), 8'h00);
    check("t5_a_ack_hi", ack_of(0), 8'd1);
    drive(1, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rd_cmd("t5_b_new", 1, 8'h80, 8'hC3, 8'd0);
    // staggered writes to one address: later commit wins
    drive(0, 1, 1, 0, 0, 8'h90);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8'h01);
    drive(1, 1, 1, 0, 0, 8'h90);
    @(negedge clk);
    check("t5_stag_b_err", err_of(1), 8'd0);
    drive(1, 0, 0, 0, 0, 8'h02);
    @(negedge clk);
    rd_cmd("t5_stag_rd", 0, 8'h90, 8'h02, 8'd0);

    // 6: reset between address and data cycles
    ctl_cmd("t6_b_hold", 1, 1, 0, 8'd0);
    drive(1, 1, 1, 0, 0, 8'h50);
    @(negedge clk);
    check("t6_b_ack_lo", ack_of(1), 8'd0);
    drive(1, 0, 0, 0, 0, 8'h77);
    reset = 1'b1;
    #1;
    check("t6_b_ack", ack_of(1), 8'd1);
    check("t6_a_ack", ack_of(0), 8'd1);
    check("t6_b_out", out_of(1), 8'd0);
    check("t6_lock", lock_of(), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    rd_cmd("t6_rd_50", 0, 8'h50, 8'h00, 8'd0);
    rd_cmd("t6_rd_10", 1, 8'h10, 8'h00, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
